hwpe_tcdm_port_bridge: RTL and testbench
========================================

// Module: hwpe_tcdm_port_bridge
// PURPOSE
//  Parametrised bridge between an HWPE accelerator's N TCDM master ports and the cluster TCDM crossbar.
//  Adds per-port request pipelining and outstanding-transaction tracking with throttling.
//  Registers the response path and the accelerator event lines.
//  Replaces the hard-tied busy with a busy_o derived from real in-flight state; sits inside the HWPE wrapper.
// PARAMETERS
//  N_CORES        2   cores receiving events; evt width N_CORES x 2
//  N_MASTER_PORT  4   TCDM master ports (>=1)
//  DW             32  TCDM data width (multiple of 8); BW = DW/8 is localparam
//  AW             32  TCDM address width
//  MAX_OUTST      4   max granted-but-unanswered transactions per port (>=1); CW = $clog2(MAX_OUTST+1)
// PORTS
//  clk          in   1             clock, all logic rising-edge
//  rst          in   1             synchronous, active-high reset
//  acc_req      in   NMP           accelerator request valid, per port
//  acc_gnt      out  NMP           accepted into port slice
//  acc_add      in   NMP x AW      address
//  acc_wen      in   NMP           1 = read, 0 = write
//  acc_be       in   NMP x BW      byte enable
//  acc_wdata    in   NMP x DW      write data
//  acc_r_valid  out  NMP           response valid (1-cycle pulse)
//  acc_r_data   out  NMP x DW      response data
//  acc_busy_i   in   1             accelerator engine busy
//  acc_evt_i    in   N_CORES x 2   accelerator event pulses
//  tcdm_req     out  NMP           crossbar request
//  tcdm_gnt     in   NMP           crossbar grant
//  tcdm_add/wen/be/wdata  out      request payload (AW/1/BW/DW per port)
//  tcdm_r_valid in   NMP           crossbar response valid
//  tcdm_r_rdata in   NMP x DW      crossbar response data
//  evt_o        out  N_CORES x 2   registered events
//  busy_o       out  1             bridge or accelerator busy
//  err_o        out  NMP           sticky: response received with nothing outstanding
// BEHAVIOUR
//  Reset: slices empty; counters 0; tcdm_req, acc_r_valid, evt_o, busy_o, err_o = 0; payload regs = 0.
//  Port slice: one-entry pipeline register, full flag f.
//   - acc_gnt = !f | fire; accept = acc_req & acc_gnt loads payload, sets f.
//   - issue_ok = (cnt < MAX_OUTST); tcdm_req = f & issue_ok; fire = tcdm_req & tcdm_gnt.
//   - fire & !accept clears f; fire & accept keeps f with new payload -> back-to-back 1 req/cycle.
//   - tcdm_req, once high, holds with stable payload until tcdm_gnt; it drops only at reset.
//   - Min latency acc_req -> tcdm_req = 1 cycle.
//  Outstanding counter cnt (CW bits), per port, counts reads and writes. Each write also returns r_valid.
//   - fire & !r_valid: +1. r_valid & !fire: -1. Both: unchanged.
//   - cnt == MAX_OUTST: tcdm_req held low; slice stays full; acc_gnt = 0.
//   - r_valid with cnt == 0: counter stays 0 (no wrap); err_o[i] set, cleared only by rst.
//  Response: acc_r_valid/acc_r_data = tcdm_r_valid/tcdm_r_rdata delayed 1 cycle.
//   - No backpressure; acc_r_data holds the last value when not valid.
//  Events: evt_o = acc_evt_i delayed 1 cycle. Each pulse is preserved 1:1.
//  busy_o (registered) = |f | (|cnt != 0) | acc_busy_i.
//   - Drops 1 cycle after the last response and acc_busy_i low.
//  Reset mid-operation: in-flight state discarded.
//   - Late crossbar responses after reset set err_o. The integrator guarantees a quiescent crossbar at reset.
//  Ports are fully independent; there is no cross-port ordering.
// STRUCTURE
//  hwpe_bridge_pkg: typedef tcdm_req_t {add, wen, be, wdata} parametrised by AW/DW (via localparams);
//   constants TCDM_READ = 1'b1, TCDM_WRITE = 1'b0.
//  Sub-module hwpe_tcdm_port_slice: slice + counter + response reg + err, one per port via generate.
//  Top holds the event regs and busy reduction.
// TESTING
//  1 Single read port0, gnt same cycle, r_valid 1 cycle later -> tcdm_req @T+1, acc_r_valid @T+3, cnt back 0.
//  2 Stream 8 writes port1, gnt always 1, r_valid 1 cycle after gnt -> 1 req/cycle, acc_gnt never drops.
//  3 MAX_OUTST=4, gnt=1, r_valid withheld -> 4 fires; 5th req held, acc_gnt=0; one r_valid -> 5th issues next cycle.
//  4 tcdm_gnt low 5 cycles with payload 0xDEADBEEF -> tcdm_req stays 1, payload stable, acc_gnt=0 after 2nd accept.
//  5 Simultaneous fire and r_valid at cnt=2 -> cnt stays 2; spurious r_valid at cnt=0 -> err_o[i]=1, cnt=0.
//  6 acc_evt_i[1][0] pulse, acc_busy_i=0, all idle -> evt_o[1][0] pulse next cycle; busy_o 0; rst mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hwpe_bridge_pkg.sv
// Shared types and constants for the HWPE <-> TCDM crossbar bridge.
// Default bus widths, the request payload record and the read/write encoding.
package hwpe_bridge_pkg;

    localparam int unsigned TCDM_AW = 32;
    localparam int unsigned TCDM_DW = 32;
    localparam int unsigned TCDM_BW = TCDM_DW / 8;

    localparam logic TCDM_READ  = 1'b1;
    localparam logic TCDM_WRITE = 1'b0;

    typedef struct packed {
        logic [TCDM_AW-1:0] add;
        logic               wen;
        logic [TCDM_BW-1:0] be;
        logic [TCDM_DW-1:0] wdata;
    } tcdm_req_t;

    // Counter must represent 0..max_outst inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_outst);
        return $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/hwpe_tcdm_port_slice.sv
// One TCDM master port: a one-entry request register, a granted-but-unanswered
// counter that throttles issue, a registered response path and a sticky error flag.
module hwpe_tcdm_port_slice
    import hwpe_bridge_pkg::*;
#(
    parameter int unsigned  AW        = TCDM_AW,
    parameter int unsigned  DW        = TCDM_DW,
    parameter int unsigned  MAX_OUTST = 4,
    localparam int unsigned BW        = DW / 8,
    localparam int unsigned CW        = cnt_width(MAX_OUTST)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc_req_i,
    output logic          acc_gnt_o,
    input  logic [AW-1:0] acc_add_i,
    input  logic          acc_wen_i,
    input  logic [BW-1:0] acc_be_i,
    input  logic [DW-1:0] acc_wdata_i,
    output logic          acc_r_valid_o,
    output logic [DW-1:0] acc_r_data_o,
    output logic          tcdm_req_o,
    input  logic          tcdm_gnt_i,
    output logic [AW-1:0] tcdm_add_o,
    output logic          tcdm_wen_o,
    output logic [BW-1:0] tcdm_be_o,
    output logic [DW-1:0] tcdm_wdata_o,
    input  logic          tcdm_r_valid_i,
    input  logic [DW-1:0] tcdm_r_rdata_i,
    output logic          busy_o,
    output logic          err_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

    logic          f_q, f_d;
    logic [AW-1:0] add_q, add_d;
    logic          wen_q, wen_d;
    logic [BW-1:0] be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          r_valid_q;
    logic [DW-1:0] r_data_q, r_data_d;
    logic          fire, accept;

    // A full slice at the outstanding limit neither issues nor accepts.
    assign tcdm_req_o = f_q & (cnt_q < CNT_MAX);
    assign fire       = tcdm_req_o & tcdm_gnt_i;
    assign acc_gnt_o  = ~f_q | fire;
    assign accept     = acc_req_i & acc_gnt_o;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
        f_d      = f_q;
        add_d    = add_q;
        wen_d    = wen_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        r_data_d = r_data_q;

        if (accept) begin
            f_d     = 1'b1;
            add_d   = acc_add_i;
            wen_d   = acc_wen_i;
            be_d    = acc_be_i;
            wdata_d = acc_wdata_i;
        end else if (fire) begin
            f_d = 1'b0;
        end

        // Saturate at zero: a stray response never wraps the counter.
        if (fire && !tcdm_r_valid_i)
            cnt_d = cnt_q + 1'b1;
        else if (tcdm_r_valid_i && !fire && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;

        if (tcdm_r_valid_i && cnt_q == '0)
            err_d = 1'b1;

        if (tcdm_r_valid_i)
            r_data_d = tcdm_r_rdata_i;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            f_q       <= 1'b0;
            add_q     <= '0;
            wen_q     <= TCDM_WRITE;
            be_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            f_q       <= f_d;
            add_q     <= add_d;
            wen_q     <= wen_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            r_valid_q <= tcdm_r_valid_i;
            r_data_q  <= r_data_d;
        end
    end

    assign tcdm_add_o    = add_q;
    assign tcdm_wen_o    = wen_q;
    assign tcdm_be_o     = be_q;
    assign tcdm_wdata_o  = wdata_q;
    assign acc_r_valid_o = r_valid_q;
    assign acc_r_data_o  = r_data_q;
    assign busy_o        = f_q | (cnt_q != '0);
    assign err_o         = err_q;

endmodule

// File: rtl/hwpe_tcdm_port_bridge.sv
// Bridge between an HWPE's TCDM master ports and the cluster crossbar: one slice
// per port, registered accelerator events and a busy flag built from in-flight state.
module hwpe_tcdm_port_bridge
    import hwpe_bridge_pkg::*;
#(
    parameter int unsigned  N_CORES       = 2,
    parameter int unsigned  N_MASTER_PORT = 4,
    parameter int unsigned  DW            = TCDM_DW,
    parameter int unsigned  AW            = TCDM_AW,
    parameter int unsigned  MAX_OUTST     = 4,
    localparam int unsigned BW            = DW / 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_MASTER_PORT-1:0]            acc_req,
    output logic [N_MASTER_PORT-1:0]            acc_gnt,
    input  logic [N_MASTER_PORT-1:0][AW-1:0]    acc_add,
    input  logic [N_MASTER_PORT-1:0]            acc_wen,
    input  logic [N_MASTER_PORT-1:0][BW-1:0]    acc_be,
    input  logic [N_MASTER_PORT-1:0][DW-1:0]    acc_wdata,
    output logic [N_MASTER_PORT-1:0]            acc_r_valid,
    output logic [N_MASTER_PORT-1:0][DW-1:0]    acc_r_data,
    input  logic                                acc_busy_i,
    input  logic [N_CORES-1:0][1:0]             acc_evt_i,
    output logic [N_MASTER_PORT-1:0]            tcdm_req,
    input  logic [N_MASTER_PORT-1:0]            tcdm_gnt,
    output logic [N_MASTER_PORT-1:0][AW-1:0]    tcdm_add,
    output logic [N_MASTER_PORT-1:0]            tcdm_wen,
    output logic [N_MASTER_PORT-1:0][BW-1:0]    tcdm_be,
    output logic [N_MASTER_PORT-1:0][DW-1:0]    tcdm_wdata,
    input  logic [N_MASTER_PORT-1:0]            tcdm_r_valid,
    input  logic [N_MASTER_PORT-1:0][DW-1:0]    tcdm_r_rdata,
    output logic [N_CORES-1:0][1:0]             evt_o,
    output logic                                busy_o,
    output logic [N_MASTER_PORT-1:0]            err_o
);

    logic [N_MASTER_PORT-1:0] port_busy;
    logic [N_CORES-1:0][1:0]  evt_q;
    logic                     busy_q, busy_d;

    for (genvar i = 0; i < N_MASTER_PORT; i++) begin : g_port
        hwpe_tcdm_port_slice #(
            .AW        (AW),
            .DW        (DW),
            .MAX_OUTST (MAX_OUTST)
        ) u_slice (
            .clk            (clk),
            .rst            (rst),
            .acc_req_i      (acc_req[i]),
            .acc_gnt_o      (acc_gnt[i]),
            .acc_add_i      (acc_add[i]),
            .acc_wen_i      (acc_wen[i]),
            .acc_be_i       (acc_be[i]),
            .acc_wdata_i    (acc_wdata[i]),
            .acc_r_valid_o  (acc_r_valid[i]),
            .acc_r_data_o   (acc_r_data[i]),
            .tcdm_req_o     (tcdm_req[i]),
            .tcdm_gnt_i     (tcdm_gnt[i]),
            .tcdm_add_o     (tcdm_add[i]),
            .tcdm_wen_o     (tcdm_wen[i]),
            .tcdm_be_o      (tcdm_be[i]),
            .tcdm_wdata_o   (tcdm_wdata[i]),
            .tcdm_r_valid_i (tcdm_r_valid[i]),
            .tcdm_r_rdata_i (tcdm_r_rdata[i]),
            .busy_o         (port_busy[i]),
            .err_o          (err_o[i])
        );
    end

    assign busy_d = (|port_busy) | acc_busy_i;

    // Events are re-timed only; each input pulse maps to exactly one output pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            evt_q  <= acc_evt_i;
            busy_q <= busy_d;
        end
    end

    assign evt_o  = evt_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_hwpe_tcdm_port_bridge.sv
// Directed bench for hwpe_tcdm_port_bridge at default parameters (4 ports, MAX_OUTST 4).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns after that.
module tb_hwpe_tcdm_port_bridge;
    import hwpe_bridge_pkg::*;

    localparam int NMP = 4;
    localparam int NC  = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NMP-1:0]            acc_req;
    logic [NMP-1:0]            acc_gnt;
    logic [NMP-1:0][31:0]      acc_add;
    logic [NMP-1:0]            acc_wen;
    logic [NMP-1:0][3:0]       acc_be;
    logic [NMP-1:0][31:0]      acc_wdata;
    logic [NMP-1:0]            acc_r_valid;
    logic [NMP-1:0][31:0]      acc_r_data;
    logic                      acc_busy_i;
    logic [NC-1:0][1:0]        acc_evt_i;
    logic [NMP-1:0]            tcdm_req;
    logic [NMP-1:0]            tcdm_gnt;
    logic [NMP-1:0][31:0]      tcdm_add;
    logic [NMP-1:0]            tcdm_wen;
    logic [NMP-1:0][3:0]       tcdm_be;
    logic [NMP-1:0][31:0]      tcdm_wdata;
    logic [NMP-1:0]            tcdm_r_valid;
    logic [NMP-1:0][31:0]      tcdm_r_rdata;
    logic [NC-1:0][1:0]        evt_o;
    logic                      busy_o;
    logic [NMP-1:0]            err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hwpe_tcdm_port_bridge #(
        .N_CORES       (NC),
        .N_MASTER_PORT (NMP),
        .DW            (32),
        .AW            (32),
        .MAX_OUTST     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .acc_req      (acc_req),
        .acc_gnt      (acc_gnt),
        .acc_add      (acc_add),
        .acc_wen      (acc_wen),
        .acc_be       (acc_be),
        .acc_wdata    (acc_wdata),
        .acc_r_valid  (acc_r_valid),
        .acc_r_data   (acc_r_data),
        .acc_busy_i   (acc_busy_i),
        .acc_evt_i    (acc_evt_i),
        .tcdm_req     (tcdm_req),
        .tcdm_gnt     (tcdm_gnt),
        .tcdm_add     (tcdm_add),
        .tcdm_wen     (tcdm_wen),
        .tcdm_be      (tcdm_be),
        .tcdm_wdata   (tcdm_wdata),
        .tcdm_r_valid (tcdm_r_valid),
        .tcdm_r_rdata (tcdm_r_rdata),
        .evt_o        (evt_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic tcdm_req_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
        return '{add: a, wen: w, be: 4'hF, wdata: d};
    endfunction

    task automatic drive(input int p, input logic req, input tcdm_req_t r);
        acc_req[p]   = req;
        acc_add[p]   = r.add;
        acc_wen[p]   = r.wen;
        acc_be[p]    = r.be;
        acc_wdata[p] = r.wdata;
    endtask

    function automatic tcdm_req_t port_payload(input int p);
        return {tcdm_add[p], tcdm_wen[p], tcdm_be[p], tcdm_wdata[p]};
    endfunction

    initial begin
        rst          = 1'b1;
        acc_req      = '0;
        acc_add      = '0;
        acc_wen      = '0;
        acc_be       = '0;
        acc_wdata    = '0;
        acc_busy_i   = 1'b0;
        acc_evt_i    = '0;
        tcdm_gnt     = '0;
        tcdm_r_valid = '0;
        tcdm_r_rdata = '0;

        // Reset state
        repeat (2) tick();
        check("rst_tcdm_req", tcdm_req, 4'h0);
        check("rst_acc_r_valid", acc_r_valid, 4'h0);
        check("rst_evt", evt_o, 4'h0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 4'h0);
        check("rst_payload0", port_payload(0), 73'h0);
        check("rst_acc_gnt", acc_gnt, 4'hF);
        rst = 1'b0;
        tick();

        // 1: single read on port 0
        drive(0, 1'b1, mk(32'h100, TCDM_READ, 32'h0));
        settle();
        check("t1_acc_gnt", acc_gnt[0], 1'b1);
        check("t1_no_req_at_T", tcdm_req[0], 1'b0);
        tick();
        drive(0, 1'b0, mk(32'h0, TCDM_WRITE, 32'h0));
        tcdm_gnt[0] = 1'b1;
        settle();
        check("t1_req_T1", tcdm_req[0], 1'b1);
        check("t1_payload", port_payload(0), mk(32'h100, TCDM_READ, 32'h0));
        tick();
        tcdm_gnt[0]     = 1'b0;
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_rdata[0] = 32'hA5A5_0001;
        settle();
        check("t1_req_dropped", tcdm_req[0], 1'b0);
        check("t1_cnt_1", dut.g_port[0].u_slice.cnt_q, 3'd1);
        check("t1_busy", busy_o, 1'b1);
        tick();
        tcdm_r_valid[0] = 1'b0;
        tcdm_r_rdata[0] = 32'h0BAD_0BAD;
        settle();
        check("t1_r_valid_T3", acc_r_valid[0], 1'b1);
        check("t1_r_data", acc_r_data[0], 32'hA5A5_0001);
        check("t1_cnt_0", dut.g_port[0].u_slice.cnt_q, 3'd0);
        tick();
        check("t1_r_valid_pulse", acc_r_valid[0], 1'b0);
        check("t1_r_data_held", acc_r_data[0], 32'hA5A5_0001);
        check("t1_busy_drop", busy_o, 1'b0);

        // 2: stream of 8 writes on port 1, response one cycle after each grant
        tcdm_gnt[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1, k < 8, mk(32'h200 + 4 * k, TCDM_WRITE, 32'h1111_1111 * (k + 1)));
            tcdm_r_valid[1] = (k >= 2 && k <= 9);
            settle();
            if (k < 8) check("t2_acc_gnt", acc_gnt[1], 1'b1);
            check("t2_tcdm_req", tcdm_req[1], (k >= 1 && k <= 8));
            if (k >= 1 && k <= 8)
                check("t2_payload", port_payload(1), mk(32'h200 + 4 * (k - 1), TCDM_WRITE, 32'h1111_1111 * k));
            tick();
        end
        drive(1, 1'b0, mk(32'h0, TCDM_WRITE, 32'h0));
        tcdm_r_valid[1] = 1'b0;
        tcdm_gnt[1]     = 1'b0;
        tick();
        check("t2_cnt_0", dut.g_port[1].u_slice.cnt_q, 3'd0);
        check("t2_err", err_o, 4'h0);

        // 3: outstanding limit on port 2
        tcdm_gnt[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(2, 1'b1, mk(32'h300 + 4 * k, TCDM_READ, 32'h0));
            settle();
            check("t3_acc_gnt", acc_gnt[2], 1'b1);
            check("t3_tcdm_req", tcdm_req[2], (k >= 1));
            tick();
        end
        drive(2, 1'b1, mk(32'h314, TCDM_READ, 32'h0));
        settle();
        check("t3_held_req", tcdm_req[2], 1'b0);
        check("t3_held_gnt", acc_gnt[2], 1'b0);
        check("t3_held_add", tcdm_add[2], 32'h310);
        check("t3_cnt_max", dut.g_port[2].u_slice.cnt_q, 3'd4);
        tick();
        drive(2, 1'b0, mk(32'h0, TCDM_WRITE, 32'h0));
        tcdm_r_valid[2] = 1'b1;
        settle();
        check("t3_rv_cycle_req", tcdm_req[2], 1'b0);
        check("t3_rv_cycle_gnt", acc_gnt[2], 1'b0);
        tick();
        tcdm_r_valid[2] = 1'b0;
        settle();
        check("t3_fifth_issue", tcdm_req[2], 1'b1);
        check("t3_fifth_add", tcdm_add[2], 32'h310);
        check("t3_fifth_gnt", acc_gnt[2], 1'b1);
        tick();
        check("t3_slice_empty", tcdm_req[2], 1'b0);
        tcdm_gnt[2]     = 1'b0;
        tcdm_r_valid[2] = 1'b1;
        repeat (4) tick();
        tcdm_r_valid[2] = 1'b0;
        tick();
        check("t3_cnt_0", dut.g_port[2].u_slice.cnt_q, 3'd0);
        check("t3_err", err_o, 4'h0);

        // 4: crossbar stalls port 3 for 5 cycles
        drive(3, 1'b1, mk(32'h400, TCDM_WRITE, 32'h1122_3344));
        settle();
        check("t4_first_gnt", acc_gnt[3], 1'b1);
        tick();
        drive(3, 1'b1, mk(32'h404, TCDM_WRITE, 32'hDEAD_BEEF));
        tcdm_gnt[3] = 1'b1;
        settle();
        check("t4_second_gnt", acc_gnt[3], 1'b1);
        tick();
        drive(3, 1'b1, mk(32'h408, TCDM_WRITE, 32'hCAFE_F00D));
        tcdm_gnt[3] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            settle();
            check("t4_stall_req", tcdm_req[3], 1'b1);
            check("t4_stall_payload", port_payload(3), mk(32'h404, TCDM_WRITE, 32'hDEAD_BEEF));
            check("t4_stall_gnt", acc_gnt[3], 1'b0);
            tick();
        end
        tcdm_gnt[3] = 1'b1;
        settle();
        check("t4_release_gnt", acc_gnt[3], 1'b1);
        tick();
        drive(3, 1'b0, mk(32'h0, TCDM_WRITE, 32'h0));
        settle();
        check("t4_next_req", tcdm_req[3], 1'b1);
        check("t4_next_payload", port_payload(3), mk(32'h408, TCDM_WRITE, 32'hCAFE_F00D));
        tick();
        tcdm_gnt[3] = 1'b0;
        settle();
        check("t4_idle", tcdm_req[3], 1'b0);
        check("t4_cnt_3", dut.g_port[3].u_slice.cnt_q, 3'd3);
        tcdm_r_valid[3] = 1'b1;
        repeat (3) tick();
        tcdm_r_valid[3] = 1'b0;
        tick();
        check("t4_cnt_0", dut.g_port[3].u_slice.cnt_q, 3'd0);

        // 5: simultaneous fire and response at cnt=2, then a spurious response
        tcdm_gnt[0] = 1'b1;
        drive(0, 1'b1, mk(32'h500, TCDM_READ, 32'h0));
        tick();
        drive(0, 1'b1, mk(32'h504, TCDM_READ, 32'h0));
        tick();
        drive(0, 1'b1, mk(32'h508, TCDM_READ, 32'h0));
        tick();
        drive(0, 1'b0, mk(32'h0, TCDM_WRITE, 32'h0));
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_rdata[0] = 32'h5555_0002;
        settle();
        check("t5_cnt_2_before", dut.g_port[0].u_slice.cnt_q, 3'd2);
        check("t5_fire_with_rv", tcdm_req[0], 1'b1);
        tick();
        tcdm_gnt[0] = 1'b0;
        settle();
        check("t5_cnt_2_after", dut.g_port[0].u_slice.cnt_q, 3'd2);
        repeat (2) tick();
        check("t5_cnt_drained", dut.g_port[0].u_slice.cnt_q, 3'd0);
        check("t5_no_err_yet", err_o, 4'h0);
        tick();
        tcdm_r_valid[0] = 1'b0;
        settle();
        check("t5_err_set", err_o, 4'b0001);
        check("t5_cnt_no_wrap", dut.g_port[0].u_slice.cnt_q, 3'd0);
        tick();
        check("t5_err_sticky", err_o, 4'b0001);

        // 6: events, accelerator busy, reset mid-burst
        acc_evt_i[1][0] = 1'b1;
        tick();
        acc_evt_i = '0;
        settle();
        check("t6_evt_pulse", evt_o, 4'b0100);
        check("t6_idle_busy", busy_o, 1'b0);
        tick();
        check("t6_evt_clear", evt_o, 4'b0000);
        acc_busy_i = 1'b1;
        tick();
        check("t6_acc_busy", busy_o, 1'b1);
        acc_busy_i = 1'b0;
        tick();
        check("t6_acc_busy_drop", busy_o, 1'b0);
        drive(1, 1'b1, mk(32'h600, TCDM_WRITE, 32'h0000_0600));
        tick();
        settle();
        check("t6_burst_req", tcdm_req[1], 1'b1);
        tick();
        check("t6_burst_busy", busy_o, 1'b1);
        rst          = 1'b1;
        acc_evt_i    = '1;
        acc_busy_i   = 1'b1;
        tcdm_r_valid = '1;
        tick();
        check("t6_rst_tcdm_req", tcdm_req, 4'h0);
        check("t6_rst_r_valid", acc_r_valid, 4'h0);
        check("t6_rst_evt", evt_o, 4'h0);
        check("t6_rst_busy", busy_o, 1'b0);
        check("t6_rst_err", err_o, 4'h0);
        check("t6_rst_payload1", port_payload(1), 73'h0);
        drive(1, 1'b0, mk(32'h0, TCDM_WRITE, 32'h0));
        acc_evt_i    = '0;
        acc_busy_i   = 1'b0;
        tcdm_r_valid = '0;
        rst          = 1'b0;
        tick();
        check("t6_post_rst_busy", busy_o, 1'b0);
        check("t6_post_rst_req", tcdm_req, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
